// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA scan-out of the 256x240x3 frame buffer.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int IMG_W   = 256;
  localparam int IMG_H   = 240;
  localparam int H_OFS   = 64;
  // Image is doubled horizontally, so it spans 2*IMG_W screen columns.
  localparam int H_IMG_END = H_OFS + 2 * IMG_W - 1;
  localparam int CLK_DIV = 2;

  typedef logic [16:0] fb_addr_t;
  typedef logic [2:0]  pixel_t;
  typedef logic [9:0]  cnt_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Read-only port of the dual-port frame buffer as seen by the scan-out stage.
interface vga_scanout_if;
  import vga_pkg::*;

  // Fixed-latency read, no handshake: rd_data reflects rd_addr one clock later.
  fb_addr_t rd_addr;
  pixel_t   rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider, raster counters and raw (unpipelined) sync/blank/frame strobes.
module vga_timing_gen import vga_pkg::*; #(
  parameter int V_VIS_LINES  = V_VIS,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP
) (
  input  logic clock,
  input  logic reset_n,
  output logic pix_en,
  output cnt_t hcnt,
  output cnt_t vcnt,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic active,
  output logic vblank,
  output logic frame_start
);

  localparam int V_TOT_L     = V_VIS_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;
  localparam int V_SYNC_ST_L = V_VIS_LINES + V_FP_LINES;
  localparam int V_SYNC_EN_L = V_SYNC_ST_L + V_SYNC_LINES - 1;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;

  assign pix_en = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= pix_en ? '0 : div + DIV_W'(1);
      if (pix_en) begin
        if (hcnt == cnt_t'(H_TOT - 1)) begin
          hcnt <= '0;
          vcnt <= (vcnt == cnt_t'(V_TOT_L - 1)) ? '0 : vcnt + cnt_t'(1);
        end else begin
          hcnt <= hcnt + cnt_t'(1);
        end
      end
    end
  end

  assign hsync_raw = !((hcnt >= cnt_t'(H_SYNC_START)) && (hcnt <= cnt_t'(H_SYNC_END)));
  assign vsync_raw = !((vcnt >= cnt_t'(V_SYNC_ST_L)) && (vcnt <= cnt_t'(V_SYNC_EN_L)));
  assign active    = (hcnt < cnt_t'(H_VIS)) && (vcnt < cnt_t'(V_VIS_LINES));
  assign vblank    = (vcnt >= cnt_t'(V_VIS_LINES));
  // Counters reach line V_VIS with div==0 for exactly one clock per frame.
  assign frame_start = (vcnt == cnt_t'(V_VIS_LINES)) && (hcnt == '0) && (div == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA 640x480 scan-out: 2x-scaled, centred image fetch plus a two-tick pixel/sync alignment pipeline.
module vga_scanout import vga_pkg::*; #(
  parameter int V_VIS_LINES  = V_VIS,
  parameter int V_FP_LINES   = V_FP,
  parameter int V_SYNC_LINES = V_SYNC,
  parameter int V_BP_LINES   = V_BP
) (
  input  logic          clock,
  input  logic          reset_n,
  vga_scanout_if.master fb,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic          hsync,
  output logic          vsync,
  output logic          vblank,
  output logic          frame_start
);

  logic     pix_en, hsync_raw, vsync_raw, active;
  cnt_t     hcnt, vcnt, img_x;
  logic     in_img;
  fb_addr_t addr_next, rd_addr_q;
  logic     in_img_d1, act_d1, hs_d1, vs_d1;
  pixel_t   rgb_q;

  vga_timing_gen #(
    .V_VIS_LINES  (V_VIS_LINES),
    .V_FP_LINES   (V_FP_LINES),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_BP_LINES   (V_BP_LINES)
  ) u_timing (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active      (active),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  assign in_img = (hcnt >= cnt_t'(H_OFS)) && (hcnt <= cnt_t'(H_IMG_END)) &&
                  (vcnt < cnt_t'(V_VIS_LINES));
  assign img_x  = hcnt - cnt_t'(H_OFS);
  // Each source pixel covers 2x2 screen pixels: drop the LSB of both coordinates.
  assign addr_next = fb_addr_t'({vcnt[8:1], 8'b0}) + fb_addr_t'(img_x >> 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      in_img_d1 <= 1'b0;
      act_d1    <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      rgb_q     <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else if (pix_en) begin
      if (in_img) rd_addr_q <= addr_next;
      in_img_d1 <= in_img;
      act_d1    <= active;
      hs_d1     <= hsync_raw;
      vs_d1     <= vsync_raw;
      // rd_data here answers the address issued on the previous pixel tick.
      rgb_q     <= (in_img_d1 && act_d1) ? fb.rd_data : '0;
      hsync     <= hs_d1;
      vsync     <= vs_d1;
    end
  end

  assign fb.rd_addr = rd_addr_q;
  assign vga_r = rgb_q[2];
  assign vga_g = rgb_q[1];
  assign vga_b = rgb_q[0];

endmodule
